// File: rtl/binary_detect_pkg.sv
`default_nettype none
// ============================================================================
// Module      : binary_detect_pkg
// Description : Shared types and constants for the binary vote detector.
// Revision    : 1.0 - initial release
// ============================================================================
package binary_detect_pkg;

    localparam int NUM_FEATURES = 6;

    // Bit positions of each feature flag inside the packed flag/mask vector.
    localparam int c_IDX_LL    = 0;
    localparam int c_IDX_NE    = 1;
    localparam int c_IDX_PS    = 2;
    localparam int c_IDX_THETA = 3;
    localparam int c_IDX_ALPHA = 4;
    localparam int c_IDX_BETA  = 5;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PENDING = 2'd1,
        DETECT  = 2'd2,
        HOLD    = 2'd3
    } state_t;

    function automatic logic [NUM_FEATURES-1:0] pack_flags(
        input logic ll,
        input logic ne,
        input logic ps,
        input logic theta,
        input logic alpha,
        input logic beta
    );
        logic [NUM_FEATURES-1:0] v;
        v              = '0;
        v[c_IDX_LL]    = ll;
        v[c_IDX_NE]    = ne;
        v[c_IDX_PS]    = ps;
        v[c_IDX_THETA] = theta;
        v[c_IDX_ALPHA] = alpha;
        v[c_IDX_BETA]  = beta;
        return v;
    endfunction

endpackage
`default_nettype wire

// File: rtl/binary_vote_detector_if.sv
`default_nettype none
// ============================================================================
// Module      : binary_vote_detector_if
// Description : Per-window feature flag bundle from the comparator stage.
//               feature_mask exists only when DETECT_MASK_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
interface binary_vote_detector_if;

    logic win_valid;
    logic ll_binary;
    logic ne_binary;
    logic ps_binary;
    logic theta_binary;
    logic alpha_binary;
    logic beta_binary;
`ifdef DETECT_MASK_EN
    logic [binary_detect_pkg::NUM_FEATURES-1:0] feature_mask;

    modport master (
        output win_valid, ll_binary, ne_binary, ps_binary,
               theta_binary, alpha_binary, beta_binary, feature_mask
    );
    modport slave (
        input  win_valid, ll_binary, ne_binary, ps_binary,
               theta_binary, alpha_binary, beta_binary, feature_mask
    );
`else
    modport master (
        output win_valid, ll_binary, ne_binary, ps_binary,
               theta_binary, alpha_binary, beta_binary
    );
    modport slave (
        input  win_valid, ll_binary, ne_binary, ps_binary,
               theta_binary, alpha_binary, beta_binary
    );
`endif

endinterface
`default_nettype wire

// File: rtl/binary_vote_detector_popcount.sv
`default_nettype none
// ============================================================================
// Module      : vote_popcount
// Description : Combinational masked popcount of the feature flags with a
//               threshold compare against VOTE_TH.
// Revision    : 1.0 - initial release
// ============================================================================
module vote_popcount
    import binary_detect_pkg::*;
#(
    parameter int VOTE_TH = 4
) (
    input  wire logic [NUM_FEATURES-1:0] i_flags,
    input  wire logic [NUM_FEATURES-1:0] i_mask,
    output logic      [2:0]              o_count,
    output logic                         o_pos
);

    localparam logic [3:0] c_TH = 4'(VOTE_TH);

    logic [NUM_FEATURES-1:0] w_hits;

    assign w_hits = i_flags & i_mask;

    always_comb begin
        o_count = 3'd0;
        for (int i = 0; i < NUM_FEATURES; i++) begin
            o_count = o_count + {2'b00, w_hits[i]};
        end
    end

    assign o_pos = ({1'b0, o_count} >= c_TH);

endmodule
`default_nettype wire

// File: rtl/binary_vote_detector.sv
`default_nettype none
// ============================================================================
// Module      : binary_vote_detector
// Description : Per-window majority vote followed by an onset / offset /
//               refractory-hold state machine and a saturating event count.
//               Optional macro DETECT_MASK_EN applies feature_mask to the vote.
// Revision    : 1.0 - initial release
// ============================================================================
module binary_vote_detector
    import binary_detect_pkg::*;
#(
    parameter int VOTE_TH    = 4,
    parameter int ONSET_WIN  = 3,
    parameter int OFFSET_WIN = 3,
    parameter int HOLD_WIN   = 8,
    parameter int CNT_W      = 8,
    parameter int EVT_W      = 16
) (
    input  wire logic               clk,
    input  wire logic               rst,
    binary_vote_detector_if.slave   win_if,
    output logic [2:0]              vote_count,
    output logic                    detect,
    output logic                    onset_pulse,
    output logic                    offset_pulse,
    output logic [EVT_W-1:0]        event_count,
    output logic [1:0]              state_o
);

    localparam logic [CNT_W-1:0] c_CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0] c_ONSET     = CNT_W'(ONSET_WIN);
    localparam logic [CNT_W-1:0] c_OFFSET    = CNT_W'(OFFSET_WIN);
    localparam logic [CNT_W-1:0] c_HOLD      = CNT_W'(HOLD_WIN);
    localparam bit               c_SKIP_HOLD = (HOLD_WIN == 0);
    localparam bit               c_FAST_ON   = (ONSET_WIN == 1);

    // ------------------------------------------------------------------
    // Stage 1: vote
    // ------------------------------------------------------------------
    logic [NUM_FEATURES-1:0] w_flags;
    logic [NUM_FEATURES-1:0] w_mask;
    logic [2:0]              w_count;
    logic                    w_pos;

    logic [2:0]              r_vote_count;
    logic                    r_pos;
    logic                    r_vld_q;

    assign w_flags = pack_flags(win_if.ll_binary, win_if.ne_binary,
                                win_if.ps_binary, win_if.theta_binary,
                                win_if.alpha_binary, win_if.beta_binary);

`ifdef DETECT_MASK_EN
    assign w_mask = win_if.feature_mask;
`else
    assign w_mask = '1;
`endif

    vote_popcount #(
        .VOTE_TH (VOTE_TH)
    ) u_vote_popcount (
        .i_flags (w_flags),
        .i_mask  (w_mask),
        .o_count (w_count),
        .o_pos   (w_pos)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_vote_count <= 3'd0;
            r_pos        <= 1'b0;
            r_vld_q      <= 1'b0;
        end else begin
            r_vld_q <= win_if.win_valid;
            if (win_if.win_valid) begin
                r_vote_count <= w_count;
                r_pos        <= w_pos;
            end
        end
    end

    // ------------------------------------------------------------------
    // Stage 2: persistence / refractory state machine
    // ------------------------------------------------------------------
    state_t            r_state;
    state_t            w_state_nxt;
    logic [CNT_W-1:0]  r_cnt;
    logic [CNT_W-1:0]  w_cnt_nxt;
    logic [CNT_W-1:0]  w_cnt_inc;
    logic              w_onset;
    logic              w_offset;

    logic              r_detect;
    logic              r_onset;
    logic              r_offset;
    logic [EVT_W-1:0]  r_event;

    assign w_cnt_inc = r_cnt + c_CNT_ONE;

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_onset     = 1'b0;
        w_offset    = 1'b0;
        if (r_vld_q) begin
            case (r_state)
                IDLE: begin
                    if (r_pos) begin
                        if (c_FAST_ON) begin
                            w_state_nxt = DETECT;
                            w_cnt_nxt   = '0;
                            w_onset     = 1'b1;
                        end else begin
                            w_state_nxt = PENDING;
                            w_cnt_nxt   = c_CNT_ONE;
                        end
                    end else begin
                        w_cnt_nxt = '0;
                    end
                end
                PENDING: begin
                    if (r_pos) begin
                        if (w_cnt_inc == c_ONSET) begin
                            w_state_nxt = DETECT;
                            w_cnt_nxt   = '0;
                            w_onset     = 1'b1;
                        end else begin
                            w_cnt_nxt = w_cnt_inc;
                        end
                    end else begin
                        w_state_nxt = IDLE;
                        w_cnt_nxt   = '0;
                    end
                end
                DETECT: begin
                    // Any positive window restarts the offset run.
                    if (!r_pos) begin
                        if (w_cnt_inc == c_OFFSET) begin
                            w_state_nxt = c_SKIP_HOLD ? IDLE : HOLD;
                            w_cnt_nxt   = '0;
                            w_offset    = 1'b1;
                        end else begin
                            w_cnt_nxt = w_cnt_inc;
                        end
                    end else begin
                        w_cnt_nxt = '0;
                    end
                end
                HOLD: begin
                    // Vote result is ignored; positives here never pre-load onset.
                    if (w_cnt_inc == c_HOLD) begin
                        w_state_nxt = IDLE;
                        w_cnt_nxt   = '0;
                    end else begin
                        w_cnt_nxt = w_cnt_inc;
                    end
                end
                default: begin
                    w_state_nxt = IDLE;
                    w_cnt_nxt   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= IDLE;
            r_cnt    <= '0;
            r_detect <= 1'b0;
            r_onset  <= 1'b0;
            r_offset <= 1'b0;
            r_event  <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_cnt    <= w_cnt_nxt;
            r_detect <= (w_state_nxt == DETECT);
            r_onset  <= w_onset;
            r_offset <= w_offset;
            if (w_onset && (r_event != {EVT_W{1'b1}})) begin
                r_event <= r_event + EVT_W'(1);
            end
        end
    end

    assign vote_count   = r_vote_count;
    assign detect       = r_detect;
    assign onset_pulse  = r_onset;
    assign offset_pulse = r_offset;
    assign event_count  = r_event;
    assign state_o      = r_state;

endmodule
`default_nettype wire

// File: tb/tb_binary_vote_detector.sv
`default_nettype none
// ============================================================================
// Module      : tb_binary_vote_detector
// Description : Scoreboard bench for binary_vote_detector; two instances
//               (default parameters and a fast / 2-bit-event variant).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_binary_vote_detector;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    binary_vote_detector_if vif ();

    logic [2:0]  vc_a, vc_b;
    logic        det_a, on_a, off_a, det_b, on_b, off_b;
    logic [15:0] ev_a;
    logic [1:0]  ev_b, st_a, st_b;

    binary_vote_detector u_dut_a (
        .clk          (clk),
        .rst          (rst),
        .win_if       (vif),
        .vote_count   (vc_a),
        .detect       (det_a),
        .onset_pulse  (on_a),
        .offset_pulse (off_a),
        .event_count  (ev_a),
        .state_o      (st_a)
    );

    binary_vote_detector #(
        .VOTE_TH    (3),
        .ONSET_WIN  (1),
        .OFFSET_WIN (1),
        .HOLD_WIN   (0),
        .CNT_W      (8),
        .EVT_W      (2)
    ) u_dut_b (
        .clk          (clk),
        .rst          (rst),
        .win_if       (vif),
        .vote_count   (vc_b),
        .detect       (det_b),
        .onset_pulse  (on_b),
        .offset_pulse (off_b),
        .event_count  (ev_b),
        .state_o      (st_b)
    );

    typedef struct {
        int st;
        int cnt;
        int evt;
        bit on;
        bit off;
    } mdl_t;

    int   n_chk = 0;
    int   n_err = 0;
    mdl_t ma, mb;
    int   qa_v[$];
    int   qb_v[$];
    mdl_t qa_f[$];
    mdl_t qb_f[$];
    bit   p1 = 1'b0;
    bit   p2 = 1'b0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference behaviour of the detector for one valid window.
    function automatic mdl_t mstep(input mdl_t m, input int vote, input int th,
                                   input int ow, input int fw, input int hw, input int emax);
        mdl_t r;
        bit   pos;
        r     = m;
        r.on  = 1'b0;
        r.off = 1'b0;
        pos   = (vote >= th);
        case (m.st)
            0: begin
                if (pos) begin
                    if (ow == 1) begin r.st = 2; r.cnt = 0; r.on = 1'b1; end
                    else begin r.st = 1; r.cnt = 1; end
                end else r.cnt = 0;
            end
            1: begin
                if (!pos) begin r.st = 0; r.cnt = 0; end
                else if (m.cnt + 1 == ow) begin r.st = 2; r.cnt = 0; r.on = 1'b1; end
                else r.cnt = m.cnt + 1;
            end
            2: begin
                if (pos) r.cnt = 0;
                else if (m.cnt + 1 == fw) begin r.st = (hw == 0) ? 0 : 3; r.cnt = 0; r.off = 1'b1; end
                else r.cnt = m.cnt + 1;
            end
            default: begin
                if (m.cnt + 1 == hw) begin r.st = 0; r.cnt = 0; end
                else r.cnt = m.cnt + 1;
            end
        endcase
        if (r.on && r.evt < emax) r.evt = r.evt + 1;
        return r;
    endfunction

    task automatic compare_fsm(input string tag, input mdl_t e, input logic [1:0] st,
                               input logic det, input logic on, input logic off, input logic [31:0] evt);
        check_val({tag, "_state"},  32'(st),  32'(e.st));
        check_val({tag, "_detect"}, 32'(det), 32'(e.st == 2));
        check_val({tag, "_onset"},  32'(on),  32'(e.on));
        check_val({tag, "_offset"}, 32'(off), 32'(e.off));
        check_val({tag, "_events"}, evt,      32'(e.evt));
    endtask

    task automatic check_all_zero(input string tag);
        check_val({tag, "_a_vote"},   32'(vc_a),  0);
        check_val({tag, "_a_state"},  32'(st_a),  0);
        check_val({tag, "_a_detect"}, 32'(det_a), 0);
        check_val({tag, "_a_onset"},  32'(on_a),  0);
        check_val({tag, "_a_offset"}, 32'(off_a), 0);
        check_val({tag, "_a_events"}, 32'(ev_a),  0);
        check_val({tag, "_b_detect"}, 32'(det_b), 0);
        check_val({tag, "_b_events"}, 32'(ev_b),  0);
    endtask

    task automatic reset_models();
        ma = '{default: 0};
        mb = '{default: 0};
        qa_v.delete();
        qb_v.delete();
        qa_f.delete();
        qb_f.delete();
    endtask

    task automatic send_win(input logic [5:0] f, input logic [5:0] m);
        logic [5:0] me;
        int         v;
        @(posedge clk);
        #1;
        vif.win_valid    = 1'b1;
        vif.ll_binary    = f[0];
        vif.ne_binary    = f[1];
        vif.ps_binary    = f[2];
        vif.theta_binary = f[3];
        vif.alpha_binary = f[4];
        vif.beta_binary  = f[5];
`ifdef DETECT_MASK_EN
        vif.feature_mask = m;
        me = m;
`else
        me = 6'h3F;
`endif
        v  = $countones(f & me);
        ma = mstep(ma, v, 4, 3, 3, 8, 65535);
        mb = mstep(mb, v, 3, 1, 1, 0, 3);
        qa_v.push_back(v);
        qb_v.push_back(v);
        qa_f.push_back(ma);
        qb_f.push_back(mb);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
            vif.win_valid = 1'b0;
        end
    endtask

    // Pipeline tracker: vote visible one cycle after win_valid, FSM two cycles after.
    always @(posedge clk) begin
        p1 <= rst ? 1'b0 : vif.win_valid;
        p2 <= rst ? 1'b0 : p1;
    end

    always @(negedge clk) begin
        if (p1) begin
            if (qa_v.size() == 0 || qb_v.size() == 0) begin
                check_val("sb_vote_nonempty", 32'(qa_v.size() > 0 && qb_v.size() > 0), 1);
            end else begin
                check_val("a_vote", 32'(vc_a), 32'(qa_v.pop_front()));
                check_val("b_vote", 32'(vc_b), 32'(qb_v.pop_front()));
            end
        end
        if (p2) begin
            if (qa_f.size() == 0 || qb_f.size() == 0) begin
                check_val("sb_fsm_nonempty", 32'(qa_f.size() > 0 && qb_f.size() > 0), 1);
            end else begin
                compare_fsm("a", qa_f.pop_front(), st_a, det_a, on_a, off_a, 32'(ev_a));
                compare_fsm("b", qb_f.pop_front(), st_b, det_b, on_b, off_b, 32'(ev_b));
            end
        end else begin
            check_val("a_onset_quiet",  32'(on_a),  0);
            check_val("a_offset_quiet", 32'(off_a), 0);
            check_val("b_onset_quiet",  32'(on_b),  0);
            check_val("b_offset_quiet", 32'(off_b), 0);
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vif.win_valid    = 1'b0;
        vif.ll_binary    = 1'b0;
        vif.ne_binary    = 1'b0;
        vif.ps_binary    = 1'b0;
        vif.theta_binary = 1'b0;
        vif.alpha_binary = 1'b0;
        vif.beta_binary  = 1'b0;
`ifdef DETECT_MASK_EN
        vif.feature_mask = 6'h3F;
`endif
        reset_models();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check_all_zero("reset");

        // Onset after three positive windows, then stays in detect.
        repeat (5) send_win(6'b001111, 6'h3F);
        // Alternating pos/neg keeps detect; then three negatives go to HOLD.
        repeat (3) begin
            send_win(6'b000001, 6'h3F);
            send_win(6'b001111, 6'h3F);
        end
        repeat (3) send_win(6'b000010, 6'h3F);
        idle(2);
        @(negedge clk);
        check_val("a_in_hold", 32'(st_a), 3);

        // Eight positives are swallowed by HOLD, next three re-trigger.
        repeat (11) send_win(6'h3F, 6'h3F);
        idle(2);
        @(negedge clk);
        check_val("a_second_onset_events", 32'(ev_a), 2);
        check_val("b_events_saturated", 32'(ev_b), 3);

        // Leave detect, drain hold, then sub-threshold windows.
        repeat (11) send_win(6'h00, 6'h3F);
        repeat (5) send_win(6'b010101, 6'h3F);
        idle(2);
        @(negedge clk);
        check_val("a_three_flags_idle", 32'(st_a), 0);

`ifdef DETECT_MASK_EN
        repeat (4) send_win(6'h3F, 6'b000111);
        repeat (4) send_win(6'b000111, 6'b000111);
        send_win(6'b111000, 6'b000111);
        idle(2);
        @(negedge clk);
        check_val("a_masked_idle", 32'(st_a), 0);
`endif

        // Random windows with random gaps.
        repeat (60) begin
            if ($urandom_range(0, 3) == 0) idle(1);
            send_win(6'($urandom_range(0, 63)), 6'($urandom_range(0, 63)));
        end
        idle(3);

        // Drive into detect, then reset while a window is offered.
        repeat (12) send_win(6'h3F, 6'h3F);
        idle(3);
        @(negedge clk);
        check_val("a_detect_before_rst", 32'(det_a), 1);
        @(posedge clk);
        #1;
        rst           = 1'b1;
        vif.win_valid = 1'b1;
        @(posedge clk);
        #1;
        rst           = 1'b0;
        vif.win_valid = 1'b0;
        reset_models();
        @(negedge clk);
        check_all_zero("midrst");

        repeat (4) send_win(6'b011110, 6'h3F);
        idle(4);
        @(negedge clk);
        check_val("sb_drain_a", 32'(qa_f.size() + qa_v.size()), 0);
        check_val("sb_drain_b", 32'(qb_f.size() + qb_v.size()), 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
